// File: rtl/ramp_adc_multi_processing.sv
// Multi-channel ramp ADC block averager with a shared scaling multiplier.
// Block sums are snapshotted, then scaled one channel at a time onto a stream.
module ramp_adc_multi_processing #(
    parameter int NUM_CH         = 4,
    parameter int IN_W           = 8,
    parameter int AVG_POWER      = 8,
    parameter int SCALING_FACTOR = 26406,
    parameter int SHIFT_FACTOR   = 19,
    parameter int OUT_W          = 16,
    localparam int ACC_W = IN_W + AVG_POWER,
    localparam int SF_W  = $clog2(SCALING_FACTOR + 1),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    input  logic [NUM_CH*IN_W-1:0]  duty_data,
    input  logic                    scale_en,
    output logic [NUM_CH*ACC_W-1:0] ave_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_sat,
    output logic                    overrun,
    output logic                    busy
);

    localparam int PROD_W = ACC_W + SF_W;
    localparam int VW     = (PROD_W > OUT_W) ? PROD_W : OUT_W;
    localparam logic [VW-1:0]   MAX_V   = VW'({OUT_W{1'b1}});
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, MULT, SHIFT, EMIT} state_t;

    state_t               state;
    state_t               next_state;
    logic [AVG_POWER-1:0] sample_cnt;
    logic [ACC_W-1:0]     acc  [NUM_CH];
    logic [ACC_W-1:0]     sums [NUM_CH];
    logic                 block_done;
    logic                 capture;
    logic [CH_W-1:0]      ch_idx;
    logic [ACC_W-1:0]     ave_sel;
    logic [PROD_W-1:0]    prod;
    logic [VW-1:0]        v;
    logic                 sat;

    assign block_done = sample_valid && (&sample_cnt);
    assign capture    = block_done && (state == IDLE);
    assign busy       = (state != IDLE);

    // Running block sums including the sample arriving this cycle
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sums[k] = acc[k] + ACC_W'(duty_data[k*IN_W +: IN_W]);
        end
    end

    // Accumulators and sample counter; never stall, reload on block completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        end else if (sample_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= block_done ? '0 : sums[k];
            end
        end
    end

    // Snapshot block sums when idle, otherwise flag the dropped block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ave_data <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= block_done && (state != IDLE);
            if (capture) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    ave_data[k*ACC_W +: ACC_W] <= sums[k];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (capture) next_state = MULT;
            MULT:    next_state = SHIFT;
            SHIFT:   next_state = EMIT;
            EMIT: begin
                if (out_ready) begin
                    next_state = (ch_idx == LAST_CH) ? IDLE : MULT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Channel pointer walks through the snapshot one handshake at a time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_idx <= '0;
        end else if (capture) begin
            ch_idx <= '0;
        end else if (state == EMIT && out_ready && ch_idx != LAST_CH) begin
            ch_idx <= ch_idx + 1'b1;
        end
    end

    // Select the snapshot word of the current channel
    always_comb begin
        ave_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == ch_idx) ave_sel = ave_data[k*ACC_W +: ACC_W];
        end
    end

    // Shared multiplier stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod <= '0;
        end else if (state == MULT) begin
            prod <= scale_en ? PROD_W'(ave_sel) * PROD_W'(SCALING_FACTOR)
                             : PROD_W'(ave_sel);
        end
    end

    // Post-multiply shift and saturation detect
    always_comb begin
        v   = scale_en ? VW'(prod >> SHIFT_FACTOR) : VW'(prod);
        sat = (v > MAX_V);
    end

    // Output registers; held stable while the sink stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (next_state == EMIT);
            if (state == SHIFT) begin
                out_data <= sat ? '1 : v[OUT_W-1:0];
                out_sat  <= sat;
                out_ch   <= ch_idx;
            end
        end
    end

endmodule

// File: tb/tb_ramp_adc_multi_processing.sv
// Scoreboard bench for ramp_adc_multi_processing: a block-sum model predicts
// captures, drops and scaled results; a negedge monitor compares them.
module tb_ramp_adc_multi_processing;

    localparam int NCH = 4;
    localparam int SF  = 26406;
    localparam int BLK = 256;

    typedef struct {
        int ch;
        int data;
        bit sat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        scale_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] duty_data = '0;

    logic [63:0] ave_data, ave_data2;
    logic        out_valid, out_valid2;
    logic        out_sat, out_sat2;
    logic        overrun, overrun2;
    logic        busy, busy2;
    logic [1:0]  out_ch, out_ch2;
    logic [15:0] out_data, out_data2;

    always #10 clk = ~clk;

    ramp_adc_multi_processing dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .duty_data(duty_data), .scale_en(scale_en), .ave_data(ave_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .out_sat(out_sat), .overrun(overrun),
        .busy(busy)
    );

    ramp_adc_multi_processing #(.SHIFT_FACTOR(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .duty_data(duty_data), .scale_en(scale_en), .ave_data(ave_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ch(out_ch2),
        .out_data(out_data2), .out_sat(out_sat2), .overrun(overrun2),
        .busy(busy2)
    );

    int          tests = 0;
    int          fails = 0;
    res_t        q[$];
    res_t        q2[$];
    int          sums[NCH];
    int          cnt = 0;
    int          pending = 0;
    logic [63:0] exp_ave = '0;
    bit          exp_ovr = 0;
    bit          lat_wait = 0;
    int          cap_cyc = 0;
    int          cyc = 0;
    bit          to_flag = 0;
    bit          done = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic void exp_res(input int s, input bit sc, input int sh,
                                    output int d, output bit st);
        longint r;
        r = sc ? ((longint'(s) * SF) >> sh) : longint'(s);
        if (r > 65535) begin
            d  = 65535;
            st = 1;
        end else begin
            d  = int'(r);
            st = 0;
        end
    endfunction

    // Monitor and reference model: check what the last edge produced, then
    // predict what the coming edge does from the inputs now on the pins.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ave", ave_data, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_ch", out_ch, 0);
            chk("rst_sat", out_sat, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data2", out_data2, 0);
            q.delete();
            q2.delete();
            for (int k = 0; k < NCH; k++) sums[k] = 0;
            cnt      = 0;
            pending  = 0;
            exp_ave  = '0;
            exp_ovr  = 0;
            lat_wait = 0;
        end else begin
            res_t e;
            int   d;
            bit   st;
            chk("timeout", to_flag, 0);
            chk("overrun", overrun, exp_ovr);
            chk("overrun2", overrun2, exp_ovr);
            chk("ave_data", ave_data, exp_ave);
            chk("ave_data2", ave_data2, exp_ave);
            chk("busy", busy, pending != 0);
            chk("busy2", busy2, pending != 0);
            chk("valid2", out_valid2, out_valid);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = q[0];
                    chk("out_ch", out_ch, e.ch);
                    chk("out_data", out_data, e.data);
                    chk("out_sat", out_sat, e.sat);
                end
                if (lat_wait) begin
                    chk("latency", cyc - cap_cyc + 1, 3);
                    lat_wait = 0;
                end
            end
            if (out_valid2 && q2.size() != 0) begin
                e = q2[0];
                chk("out_ch2", out_ch2, e.ch);
                chk("out_data2", out_data2, e.data);
                chk("out_sat2", out_sat2, e.sat);
            end
            cyc++;
            exp_ovr = 0;
            if (sample_valid) begin
                for (int k = 0; k < NCH; k++) sums[k] += duty_data[k*8 +: 8];
                cnt++;
                if (cnt == BLK) begin
                    if (pending == 0) begin
                        for (int k = 0; k < NCH; k++) begin
                            exp_ave[k*16 +: 16] = sums[k][15:0];
                            exp_res(sums[k], scale_en, 19, d, st);
                            q.push_back('{k, d, st});
                            exp_res(sums[k], scale_en, 0, d, st);
                            q2.push_back('{k, d, st});
                        end
                        pending  = NCH;
                        cap_cyc  = cyc;
                        lat_wait = 1;
                    end else begin
                        exp_ovr = 1;
                    end
                    for (int k = 0; k < NCH; k++) sums[k] = 0;
                    cnt = 0;
                end
            end
            if (out_valid && out_ready && pending > 0) begin
                void'(q.pop_front());
                if (q2.size() != 0) void'(q2.pop_front());
                pending--;
                if (pending > 0) begin
                    cap_cyc  = cyc;
                    lat_wait = 1;
                end
            end
            if (done) begin
                chk("drain", q.size(), 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input logic [31:0] data, input bit rnd);
        for (int i = 0; i < n; i++) begin
            step();
            sample_valid = 1'b1;
            duty_data    = rnd ? 32'($urandom) : data;
        end
        step();
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd_ready);
        int t = 0;
        do begin
            step();
            out_ready = rnd_ready ? 1'($urandom) : 1'b1;
            t++;
        end while (busy && t < 400);
        if (t >= 400) to_flag = 1;
        out_ready = 1'b1;
    endtask

    // Stimulus
    initial begin
        int st;
        int n;
        for (int i = 0; i < NCH; i++) sums[i] = 0;
        reset_n = 1'b0;
        repeat (4) begin
            step();
            sample_valid = 1'($urandom);
            duty_data    = 32'($urandom);
            out_ready    = 1'($urandom);
            scale_en     = 1'($urandom);
        end
        step();
        reset_n      = 1'b1;
        sample_valid = 1'b0;
        duty_data    = '0;
        out_ready    = 1'b1;
        scale_en     = 1'b1;
        repeat (5) step();

        feed(BLK, 32'h0000_0064, 0);
        wait_idle(0);

        feed(BLK, 32'hFFFF_FFFF, 0);
        wait_idle(0);
        scale_en = 1'b0;
        feed(BLK, 32'hFFFF_FFFF, 0);
        wait_idle(0);

        scale_en  = 1'b1;
        out_ready = 1'b1;
        st = 0;
        for (int i = 0; i < 3 * BLK; i++) begin
            step();
            sample_valid = 1'b1;
            duty_data    = 32'($urandom);
            if (st == 0 && out_valid && out_ch == 2'd1) begin
                out_ready = 1'b0;
                st = 1;
            end else if (st == 1 && i >= 520) begin
                out_ready = 1'b1;
                st = 2;
            end
        end
        step();
        sample_valid = 1'b0;
        wait_idle(0);

        for (int f = 0; f < 3; f++) begin
            scale_en = 1'($urandom);
            n = 0;
            while (n < BLK) begin
                step();
                sample_valid = ($urandom_range(0, 3) != 0);
                duty_data    = 32'($urandom);
                out_ready    = 1'($urandom);
                if (sample_valid) n++;
            end
            step();
            sample_valid = 1'b0;
            wait_idle(1);
        end

        scale_en  = 1'b1;
        out_ready = 1'b0;
        feed(BLK, 32'h0, 1);
        for (int i = 0; i < 100; i++) begin
            step();
            sample_valid = 1'b1;
            duty_data    = 32'($urandom);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n      = 1'b1;
        sample_valid = 1'b0;
        out_ready    = 1'b1;
        feed(BLK - 1, 32'h0, 1);
        repeat (5) step();
        feed(1, 32'h1020_3040, 0);
        wait_idle(0);

        repeat (3) step();
        done = 1;
        repeat (5) step();
        $display("FAIL end: monitor did not finish");
        $fatal(1);
    end

endmodule
